rsa_crt_sequencer: RTL and testbench

Sequences one RSA-CRT decryption over a single shared modular-multiplier unit.
- Computes m1 = c^dp mod p and m2 = c^dq mod q.
- Interleaves the two exponentiation channels on the multiplier round-robin.
- Then runs Garner recombination: h = qinv*(m1-m2) mod p, m = m2 + h*q.
- Sits between the key/ciphertext registers and the modmul unit, replacing the free-running CRT path with a start/busy/done-controlled schedule.

---
 rtl/rsa_seq_pkg.sv | 21 ++
 rtl/rsa_rr_arb2.sv | 28 ++
 rtl/rsa_crt_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_rsa_crt_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_seq_pkg.sv
// Shared types for the RSA-CRT sequencer: FSM states, multiplier op kinds, channel ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rsa_seq_pkg;

    localparam int W_DEF  = 32;
    localparam int CW_DEF = 6;

    typedef enum logic [2:0] {
        IDLE, LOAD, EXP, RED, SUB, HMUL, RECOMB, DONE
    } state_t;

    typedef enum logic [1:0] {
        REDUCE, SQ, MUL
    } op_t;

    typedef enum logic {
        CH_P, CH_Q
    } ch_t;

endpackage

// File: rtl/rsa_rr_arb2.sv
// Two-channel round-robin picker for the exponentiation phase.
// Latency: grant updates on the edge where adv (multiplier ack) is seen; init forces CH_P.
// Backpressure: none; the grant only moves when the current op is acknowledged.
// Ports: clk, rst (sync, active-high), init (reload to CH_P), adv (op acked),
//        pend_p/pend_q (channel still has ops after this ack), grant (registered).
module rsa_rr_arb2
    import rsa_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic adv,
    input  logic pend_p,
    input  logic pend_q,
    output ch_t  grant
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            grant <= CH_P;
        end else if (adv) begin
            // Hand over to the other channel when it has work, else stay put.
            if (grant == CH_P) grant <= pend_q ? CH_Q : CH_P;
            else               grant <= pend_p ? CH_P : CH_Q;
        end
    end

endmodule

// File: rtl/rsa_crt_sequencer.sv
// RSA-CRT decryption scheduler driving one shared modular multiplier (two interleaved exponentiations + Garner).
// Latency: 2 + sum(1 + W + popcount(exp)) multiplier ops, each at least 2 cycles, plus 4 fixed cycles.
// Backpressure: mm_req is held with stable operands until mm_ack; start is ignored unless idle.
// Ports: clk, rst (sync, active-high); start + c/p/q/dp/dq/qinv operand sample; busy, done, m (2W);
//        multiplier port mm_req/mm_a/mm_b/mm_n out, mm_ack/mm_r in.
// Option: define RSA_SEQ_SKIP_LZ_EN to start each exponent scan at its highest set bit.
module rsa_crt_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   p,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   dp,
    input  logic [W-1:0]   dq,
    input  logic [W-1:0]   qinv,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] m,
    output logic           mm_req,
    output logic [W-1:0]   mm_a,
    output logic [W-1:0]   mm_b,
    output logic [W-1:0]   mm_n,
    input  logic           mm_ack,
    input  logic [W-1:0]   mm_r
);

    state_t        state;
    logic [W-1:0]  c_r, p_r, q_r, dp_r, dq_r, qinv_r;
    logic [W-1:0]  acc  [2];
    logic [W-1:0]  base [2];
    logic [CW-1:0] kidx [2];
    op_t           op   [2];
    logic          fin  [2];
    logic [W-1:0]  t_r, diff_r, h_r;
    ch_t           grant;

    logic [W-1:0]  cur_exp, cur_n, iss_a, iss_b;
    logic [CW-1:0] cur_k;
    op_t           cur_op;
    logic          cur_bit, fin_after, pend_p_nx, pend_q_nx, exp_ack;

`ifdef RSA_SEQ_SKIP_LZ_EN
    function automatic logic [CW-1:0] msb_idx(input logic [W-1:0] e);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) if (e[i]) r = CW'(i);
        return r;
    endfunction
`endif

    always_comb begin
        cur_exp = (grant == CH_P) ? dp_r : dq_r;
        cur_n   = (grant == CH_P) ? p_r  : q_r;
        cur_k   = kidx[grant];
        cur_op  = op[grant];
        cur_bit = 1'b0;
        for (int i = 0; i < W; i++) if (cur_k == CW'(i)) cur_bit = cur_exp[i];
        iss_a     = c_r;
        iss_b     = W'(1);
        fin_after = 1'b0;
        case (cur_op)
            REDUCE: begin
                iss_a = c_r;
                iss_b = W'(1);
`ifdef RSA_SEQ_SKIP_LZ_EN
                // A zero exponent has no bits to scan: done once the base is reduced.
                fin_after = (cur_exp == '0);
`else
                fin_after = 1'b0;
`endif
            end
            SQ: begin
                iss_a     = acc[grant];
                iss_b     = acc[grant];
                fin_after = !cur_bit && (cur_k == '0);
            end
            MUL: begin
                iss_a     = acc[grant];
                iss_b     = base[grant];
                fin_after = (cur_k == '0);
            end
            default: ;
        endcase
        // Pending status as it will be after the current op retires; the arbiter consumes it on ack.
        pend_p_nx = (grant == CH_P) ? !fin_after : !fin[CH_P];
        pend_q_nx = (grant == CH_Q) ? !fin_after : !fin[CH_Q];
        exp_ack   = (state == EXP) && mm_req && mm_ack;
    end

    rsa_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .init   (state == LOAD),
        .adv    (exp_ack),
        .pend_p (pend_p_nx),
        .pend_q (pend_q_nx),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            m      <= '0;
            mm_req <= 1'b0;
            mm_a   <= '0;
            mm_b   <= '0;
            mm_n   <= '0;
            c_r    <= '0;
            p_r    <= '0;
            q_r    <= '0;
            dp_r   <= '0;
            dq_r   <= '0;
            qinv_r <= '0;
            t_r    <= '0;
            diff_r <= '0;
            h_r    <= '0;
            for (int i = 0; i < 2; i++) begin
                acc[i]  <= '0;
                base[i] <= '0;
                kidx[i] <= '0;
                op[i]   <= REDUCE;
                fin[i]  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        c_r    <= c;
                        p_r    <= p;
                        q_r    <= q;
                        dp_r   <= dp;
                        dq_r   <= dq;
                        qinv_r <= qinv;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 2; i++) begin
                        acc[i] <= W'(1);
                        op[i]  <= REDUCE;
                        fin[i] <= 1'b0;
                    end
`ifdef RSA_SEQ_SKIP_LZ_EN
                    kidx[CH_P] <= msb_idx(dp_r);
                    kidx[CH_Q] <= msb_idx(dq_r);
`else
                    kidx[CH_P] <= CW'(W - 1);
                    kidx[CH_Q] <= CW'(W - 1);
`endif
                    state <= EXP;
                end
                EXP: begin
                    if (mm_req && mm_ack) begin
                        mm_req <= 1'b0;
                        case (cur_op)
                            REDUCE: begin
                                base[grant] <= mm_r;
                                op[grant]   <= SQ;
                                fin[grant]  <= fin_after;
                            end
                            SQ: begin
                                acc[grant] <= mm_r;
                                if (cur_bit)            op[grant]   <= MUL;
                                else if (cur_k == '0)   fin[grant]  <= 1'b1;
                                else                    kidx[grant] <= cur_k - CW'(1);
                            end
                            MUL: begin
                                acc[grant] <= mm_r;
                                op[grant]  <= SQ;
                                if (cur_k == '0) fin[grant]  <= 1'b1;
                                else             kidx[grant] <= cur_k - CW'(1);
                            end
                            default: ;
                        endcase
                    end else if (!mm_req) begin
                        if (fin[CH_P] && fin[CH_Q]) begin
                            state <= RED;
                        end else begin
                            mm_req <= 1'b1;
                            mm_a   <= iss_a;
                            mm_b   <= iss_b;
                            mm_n   <= cur_n;
                        end
                    end
                end
                RED: begin
                    // m2 lives mod q and may exceed p when q > p; bring it into range first.
                    if (mm_req && mm_ack) begin
                        mm_req <= 1'b0;
                        t_r    <= mm_r;
                        state  <= SUB;
                    end else if (!mm_req) begin
                        mm_req <= 1'b1;
                        mm_a   <= acc[CH_Q];
                        mm_b   <= W'(1);
                        mm_n   <= p_r;
                    end
                end
                SUB: begin
                    // Both operands are < p, so m1 + (p - t) < p and never overflows W bits.
                    diff_r <= (acc[CH_P] >= t_r) ? (acc[CH_P] - t_r) : (acc[CH_P] + (p_r - t_r));
                    state  <= HMUL;
                end
                HMUL: begin
                    if (mm_req && mm_ack) begin
                        mm_req <= 1'b0;
                        h_r    <= mm_r;
                        state  <= RECOMB;
                    end else if (!mm_req) begin
                        mm_req <= 1'b1;
                        mm_a   <= qinv_r;
                        mm_b   <= diff_r;
                        mm_n   <= p_r;
                    end
                end
                RECOMB: begin
                    m     <= {{W{1'b0}}, acc[CH_Q]} + ((2*W)'(h_r) * (2*W)'(q_r));
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_crt_sequencer.sv
// Directed bench for rsa_crt_sequencer with a behavioural modular-multiplier responder.
// Latency: multiplier model acks 1 cycle after a request, or 1..7 cycles in random mode.
// Backpressure: model holds mm_ack off for the chosen latency and watches operand stability.
module tb_rsa_crt_sequencer;

    localparam int W = 32;
`ifdef RSA_SEQ_SKIP_LZ_EN
    localparam int OPS_A = 23;
    localparam int ALT_A = 20;
`else
    localparam int OPS_A = 75;
    localparam int ALT_A = 72;
`endif

    logic           clk = 1'b0;
    logic           rst, start;
    logic [W-1:0]   c, p, q, dp, dq, qinv;
    logic           busy, done;
    logic [2*W-1:0] m;
    logic           mm_req;
    logic [W-1:0]   mm_a, mm_b, mm_n;
    logic           ack_m = 1'b0;
    logic           stray_ack;
    logic [W-1:0]   mm_r = '0;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] sb [$];
    logic [W-1:0]   n_log [$];
    logic [W-1:0]   a_log [$];
    int  stab_err = 0;
    int  done_cnt = 0;
    bit  lat_rand = 1'b0;

    bit           active = 1'b0;
    int           cnt, lat;
    logic [W-1:0] a0, b0, n0;
    logic [2*W-1:0] prod;

    always #5 clk = ~clk;

    rsa_crt_sequencer #(.W(W), .CW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .c      (c),
        .p      (p),
        .q      (q),
        .dp     (dp),
        .dq     (dq),
        .qinv   (qinv),
        .busy   (busy),
        .done   (done),
        .m      (m),
        .mm_req (mm_req),
        .mm_a   (mm_a),
        .mm_b   (mm_b),
        .mm_n   (mm_n),
        .mm_ack (ack_m | stray_ack),
        .mm_r   (mm_r)
    );

    // Multiplier responder: one transaction at a time, result computed from the latched operands.
    always @(posedge clk) begin
        #1;
        if (done) done_cnt++;
        if (rst) begin
            ack_m  = 1'b0;
            active = 1'b0;
        end else if (ack_m) begin
            ack_m = 1'b0;
        end else if (mm_req) begin
            if (!active) begin
                active = 1'b1;
                cnt    = 0;
                lat    = lat_rand ? int'($urandom_range(7, 1)) : 1;
                a0 = mm_a; b0 = mm_b; n0 = mm_n;
            end else if (mm_a !== a0 || mm_b !== b0 || mm_n !== n0) begin
                stab_err++;
            end
            cnt++;
            if (cnt >= lat) begin
                prod   = ({{W{1'b0}}, a0} * {{W{1'b0}}, b0}) % {{W{1'b0}}, n0};
                mm_r   = prod[W-1:0];
                ack_m  = 1'b1;
                active = 1'b0;
                n_log.push_back(n0);
                a_log.push_back(a0);
            end
        end else begin
            active = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [W-1:0] cc, pp, qq, ddp, ddq, qi, input logic [2*W-1:0] em);
        c = cc; p = pp; q = qq; dp = ddp; dq = ddq; qinv = qi;
        n_log.delete();
        a_log.delete();
        sb.push_back(em);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves the caller in the cycle where done is high.
    task automatic wait_done(input string tag);
        int cyc;
        logic [2*W-1:0] em;
        cyc = 0;
        while (!done && cyc < 5000) begin
            tick();
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed=no_done expected=done", tag);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s unexpected_done observed=done expected=none", tag);
        end else begin
            em = sb.pop_front();
            chk(tag, m, em);
            chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic check_alt(input string tag, input int len, input logic [W-1:0] pp, qq);
        int bad;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (i >= n_log.size()) bad++;
            else if (n_log[i] !== ((i % 2 == 0) ? pp : qq)) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, e, n);
        logic [2*W-1:0] r, x;
        r = 1;
        x = {{W{1'b0}}, b} % {{W{1'b0}}, n};
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % {{W{1'b0}}, n};
            x = (x * x) % {{W{1'b0}}, n};
        end
        return r[W-1:0];
    endfunction

    initial begin
        int d0;
        logic [W-1:0] c60;
        rst = 1'b1; start = 1'b0; stray_ack = 1'b0;
        c = '0; p = '0; q = '0; dp = '0; dq = '0; qinv = '0;
        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_busy",   {63'd0, busy},   64'd0);
        chk("rst_done",   {63'd0, done},   64'd0);
        chk("rst_m",      m,               64'd0);
        chk("rst_mm_req", {63'd0, mm_req}, 64'd0);
        chk("rst_mm_a",   64'(mm_a),       64'd0);
        chk("rst_mm_b",   64'(mm_b),       64'd0);
        chk("rst_mm_n",   64'(mm_n),       64'd0);

        // Reference key, single-cycle multiplier.
        d0 = done_cnt;
        start_job(2790, 61, 53, 53, 49, 38, 65);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done("jobA_m");
        chk("jobA_ops", 64'(n_log.size()), 64'(OPS_A));
        check_alt("jobA_alt", ALT_A, 61, 53);
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        tick(3);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);

        start_job(0, 61, 53, 53, 49, 38, 0);
        wait_done("c0_m");
        tick();
        start_job(1, 61, 53, 53, 49, 38, 1);
        wait_done("c1_m");
        tick();
        start_job(2790, 61, 53, 0, 0, 38, 1);
        wait_done("exp0_m");
        tick();

        // Random multiplier latency.
        lat_rand = 1'b1;
        stab_err = 0;
        start_job(2790, 61, 53, 53, 49, 38, 65);
        wait_done("rand_m");
        chk("rand_stable", 64'(stab_err), 64'd0);
        check_alt("rand_alt", ALT_A, 61, 53);
        lat_rand = 1'b0;
        tick();

        // q > p: q^-1 mod p is 20 for this pair.
        start_job(2790, 53, 61, 49, 53, 20, 65);
        wait_done("qgtp_m");
        tick();
        c60 = modexp(60, 17, 3233);
        start_job(c60, 53, 61, 49, 53, 20, 60);
        wait_done("qgtp_m60");
        chk("red_a_m2", (a_log.size() >= 2) ? 64'(a_log[a_log.size()-2]) : 64'hFFFF, 64'd60);
        chk("red_n_p",  (n_log.size() >= 2) ? 64'(n_log[n_log.size()-2]) : 64'hFFFF, 64'd53);
        tick();

        // Start while busy and start in the done cycle are both ignored.
        start_job(2790, 61, 53, 53, 49, 38, 65);
        tick(20);
        c = 1; dp = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start_m");
        c = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", {63'd0, busy}, 64'd0);
        tick(3);
        chk("done_start_req", {63'd0, mm_req}, 64'd0);

        // Reset in the middle of the exponentiation.
        start_job(2790, 61, 53, 53, 49, 38, 65);
        tick(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", {63'd0, busy},   64'd0);
        chk("abort_req",  {63'd0, mm_req}, 64'd0);
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick(2);
        chk("stray_ack_busy", {63'd0, busy},   64'd0);
        chk("stray_ack_req",  {63'd0, mm_req}, 64'd0);
        start_job(2790, 61, 53, 53, 49, 38, 65);
        wait_done("after_abort_m");

        // Back-to-back: second start the cycle after done.
        tick();
        start_job(1, 61, 53, 53, 49, 38, 1);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        tick(10);
        chk("b2b_m_held", m, 64'd65);
        wait_done("b2b_m");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
